// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch/memory stages, the arbiter and the unified memory.
// Pure wiring, no latency; requesters hold their level until the matching done pulse.
// The arbiter uses the slave modport; the stages and the memory model use the master side.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          dm_rd;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;

    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          err;
    logic          busy;

    modport slave (
        input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        output if_rdata, if_done, dm_rdata, dm_done, err, busy
    );

    modport master (
        output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        input  if_rdata, if_done, dm_rdata, dm_done, err, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-ported memory between fetch (IF) and data (DM) requesters.
// Latency: LAT+1 cycles from request sample to done pulse; rejected requests complete in 1.
// Backpressure: requesters hold their level until done; the other port waits in IDLE.
module mem_arbiter #(
    parameter int LAT = 4,
    parameter int AW  = 16,
    parameter int DW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, ACC_I, ACC_D} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t        state;
    logic [3:0]    cnt;

    logic          dm_req;
    logic          if_ok;
    logic          req_bad;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    // A port whose done is high this cycle is still dropping its level; keep it out of arbitration.
    assign dm_req = (bus.dm_rd | bus.dm_wr) & ~bus.dm_done;
    assign if_ok  = bus.if_req & ~bus.if_done;

    always_comb begin
        req_addr  = bus.if_addr;
        req_wdata = '0;
        req_bad   = bus.if_addr[0];
        if (dm_req) begin
            req_addr  = bus.dm_addr;
            req_wdata = bus.dm_wdata;
            req_bad   = (bus.dm_rd & bus.dm_wr) | bus.dm_addr[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.mem_rd    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.if_done   <= 1'b0;
            bus.dm_rdata  <= '0;
            bus.dm_done   <= 1'b0;
            bus.err       <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.if_done <= 1'b0;
            bus.dm_done <= 1'b0;
            bus.err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (dm_req || if_ok) begin
                        if (req_bad) begin
                            // Rejected: no strobe, answer next cycle with err alongside done.
                            bus.err     <= 1'b1;
                            bus.dm_done <= dm_req;
                            bus.if_done <= ~dm_req;
                        end else begin
                            state         <= dm_req ? ACC_D : ACC_I;
                            cnt           <= CNT_INIT;
                            bus.mem_rd    <= dm_req ? bus.dm_rd : 1'b1;
                            bus.mem_wr    <= dm_req & bus.dm_wr;
                            bus.mem_addr  <= req_addr;
                            bus.mem_wdata <= req_wdata;
                            bus.busy      <= 1'b1;
                        end
                    end
                end
                ACC_I, ACC_D: begin
                    if (cnt == 4'd0) begin
                        state      <= IDLE;
                        bus.mem_rd <= 1'b0;
                        bus.mem_wr <= 1'b0;
                        bus.busy   <= 1'b0;
                        if (state == ACC_I) begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_done  <= 1'b1;
                        end else begin
                            if (bus.mem_rd) begin
                                bus.dm_rdata <= bus.mem_rdata;
                            end
                            bus.dm_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
